// File: rtl/boot_pkg.sv
// Shared types and byte constants for the UART boot loader.
// Frame checksum support is selected with BOOT_CHECKSUM_EN.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_SYNC,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CHECK,
        ST_SEND,
        ST_RUN
    } boot_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

endpackage

// File: rtl/boot_word_packer.sv
// Packs little-endian bytes into 32-bit words.
// Emits a one-cycle word-ready strobe after the 4th byte.
module boot_word_packer (
    input  logic        clk,
    input  logic        rstB,
    input  logic        clkEn,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_rdy,
    output logic [31:0] word
);

    logic [1:0]  r_cnt;
    logic [31:0] r_word;
    logic        r_rdy;

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            r_cnt  <= '0;
            r_word <= '0;
            r_rdy  <= 1'b0;
        end else if (clkEn) begin
            r_rdy <= byte_valid && (r_cnt == 2'd3);
            if (clr) begin
                r_cnt <= '0;
            end else if (byte_valid) begin
                r_word[{r_cnt, 3'b000} +: 8] <= byte_data;
                r_cnt <= r_cnt + 2'd1;
            end
        end
    end

    assign word_rdy = r_rdy;
    assign word     = r_word;

endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader: parses a framed UART image into IMEM, then releases the core.
// Define BOOT_CHECKSUM_EN to require a trailing frame checksum byte.
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 17360
) (
    input  logic              clk,
    input  logic              rstB,
    input  logic              clkEn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_err,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rstB,
    output logic              boot_busy,
    output logic              boot_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    boot_state_t       r_state;
    logic [7:0]        r_len_lo;
    logic [15:0]       r_len;
    logic [ADDR_W-1:0] r_idx;
    logic [TW-1:0]     r_tmo;
    logic              r_tx_valid;
    logic [7:0]        r_tx_data;
    logic              r_core_rstB;
    logic              r_boot_busy;
    logic              r_boot_err;

    logic        w_active;
    logic        w_tmo_hit;
    logic [15:0] w_len;
    logic        w_len_big;
    logic        w_last;
    logic        w_nak;
    logic        w_done;
    logic        w_ack;
    logic        w_pk_valid;
    logic        w_word_rdy;
    logic [31:0] w_word;

    assign w_active  = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                       (r_state == ST_DATA)   || (r_state == ST_CHECK);
    assign w_tmo_hit = w_active && (r_tmo == TW'(TIMEOUT_CYC - 1));
    assign w_len     = {rx_data, r_len_lo};
    assign w_len_big = {1'b0, w_len} > 17'(2 ** ADDR_W);
    assign w_last    = (16'(r_idx) == (r_len - 16'd1));
    assign w_done    = (r_state == ST_LEN_HI && rx_valid && w_len == 16'd0) ||
                       (r_state == ST_DATA && w_word_rdy && w_last);

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       w_sum_ok;

    assign w_sum_ok = (r_sum + rx_data) == 8'd0;
    assign w_ack    = (r_state == ST_CHECK) && rx_valid && w_sum_ok;
    assign w_nak    = (w_active && (rx_err || w_tmo_hit)) ||
                      (r_state == ST_LEN_HI && rx_valid && w_len_big) ||
                      (r_state == ST_CHECK && rx_valid && !w_sum_ok);

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            r_sum <= '0;
        end else if (clkEn) begin
            if (r_state == ST_WAIT_SYNC)
                r_sum <= '0;
            else if (rx_valid && (r_state == ST_LEN_LO || r_state == ST_LEN_HI ||
                                  r_state == ST_DATA))
                r_sum <= r_sum + rx_data;
        end
    end
`else
    assign w_ack = w_done;
    assign w_nak = (w_active && (rx_err || w_tmo_hit)) ||
                   (r_state == ST_LEN_HI && rx_valid && w_len_big);
`endif

    // Error wins over a coincident byte so a bad byte never reaches IMEM.
    assign w_pk_valid = (r_state == ST_DATA) && rx_valid && !w_nak;

    boot_word_packer u_packer (
        .clk        (clk),
        .rstB       (rstB),
        .clkEn      (clkEn),
        .clr        (r_state != ST_DATA),
        .byte_valid (w_pk_valid),
        .byte_data  (rx_data),
        .word_rdy   (w_word_rdy),
        .word       (w_word)
    );

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            r_state     <= ST_WAIT_SYNC;
            r_len_lo    <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_tmo       <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
            r_core_rstB <= 1'b0;
            r_boot_busy <= 1'b1;
            r_boot_err  <= 1'b0;
        end else if (clkEn) begin
            r_tmo <= (w_active && !rx_valid) ? r_tmo + TW'(1) : '0;
            if (w_nak) begin
                r_state    <= ST_SEND;
                r_tx_valid <= 1'b1;
                r_tx_data  <= NAK_BYTE;
            end else if (w_ack) begin
                r_state    <= ST_SEND;
                r_tx_valid <= 1'b1;
                r_tx_data  <= ACK_BYTE;
            end else if (w_done) begin
                r_state <= ST_CHECK;
            end else begin
                unique case (r_state)
                    ST_WAIT_SYNC: begin
                        if (rx_valid && rx_data == SYNC_BYTE) begin
                            r_state    <= ST_LEN_LO;
                            r_idx      <= '0;
                            r_boot_err <= 1'b0;
                        end
                    end
                    ST_LEN_LO: begin
                        if (rx_valid) begin
                            r_len_lo <= rx_data;
                            r_state  <= ST_LEN_HI;
                        end
                    end
                    ST_LEN_HI: begin
                        if (rx_valid) begin
                            r_len   <= w_len;
                            r_state <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (w_word_rdy)
                            r_idx <= r_idx + ADDR_W'(1);
                    end
                    ST_CHECK: begin
                    end
                    ST_SEND: begin
                        if (tx_ready) begin
                            r_tx_valid <= 1'b0;
                            if (r_tx_data == ACK_BYTE) begin
                                r_state     <= ST_RUN;
                                r_core_rstB <= 1'b1;
                                r_boot_busy <= 1'b0;
                            end else begin
                                r_state    <= ST_WAIT_SYNC;
                                r_boot_err <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                    end
                    default: r_state <= ST_WAIT_SYNC;
                endcase
            end
        end
    end

    assign tx_valid   = r_tx_valid;
    assign tx_data    = r_tx_data;
    assign imem_we    = w_word_rdy;
    assign imem_addr  = r_idx;
    assign imem_wdata = w_word;
    assign core_rstB  = r_core_rstB;
    assign boot_busy  = r_boot_busy;
    assign boot_err   = r_boot_err;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: frame table plus stall/error sequences.
// Sends the checksum byte only when BOOT_CHECKSUM_EN is defined.
module tb_uart_boot_loader;

    localparam int AW  = 10;
    localparam int TMO = 300;
    localparam int GAP = 20;

    logic          clk = 1'b0;
    logic          rstB;
    logic          clkEn;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_err;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rstB;
    logic          boot_busy;
    logic          boot_err;

    uart_boot_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
        .clk        (clk),
        .rstB       (rstB),
        .clkEn      (clkEn),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_err     (rx_err),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rstB  (core_rstB),
        .boot_busy  (boot_busy),
        .boot_err   (boot_err)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          we_cnt = 0;
    logic [31:0] mem [0:3];

    always @(negedge clk) begin
        if (imem_we) begin
            we_cnt = we_cnt + 1;
            if (imem_addr < 4) mem[imem_addr[1:0]] = imem_wdata;
        end
    end

    typedef struct {
        string       nm;
        int          n;
        logic [7:0]  b [12];
        logic [7:0]  ck;
        bit          has_ck;
        logic [7:0]  exp_tx;
        int          exp_we;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t v [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({tx_valid, tx_data, imem_we, imem_addr, imem_wdata,
                    core_rstB, boot_busy, boot_err});
    endfunction

    task automatic do_reset();
        rstB = 1'b0; clkEn = 1'b1; rx_valid = 1'b0; rx_data = '0;
        rx_err = 1'b0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        rstB = 1'b1;
        we_cnt = 0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send_ck(input logic [7:0] c);
`ifdef BOOT_CHECKSUM_EN
        send_byte(c);
`else
        if (c === 8'hxx) $display("unused");
`endif
    endtask

    task automatic send_vec(input int k);
        for (int i = 0; i < v[k].n; i++) send_byte(v[k].b[i]);
        if (v[k].has_ck) send_ck(v[k].ck);
    endtask

    task automatic wait_tx(input string nm, input logic [7:0] exp, input int hold);
        int  k;
        bit  stable;
        k = 0;
        while (!tx_valid && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (!tx_valid) begin
            n_chk++; n_err++;
            $display("FAIL %s: got no tx_valid want %0h", nm, exp);
        end else begin
            chk(nm, 64'(tx_data), 64'(exp));
            stable = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (!tx_valid || tx_data !== exp) stable = 1'b0;
            end
            if (hold > 0) chk({nm, " stall"}, 64'(stable), 64'd1);
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
        end
    endtask

    task automatic chk_post(input string nm, input logic ack);
        chk(nm, 64'({tx_valid, core_rstB, boot_busy, boot_err}),
            ack ? 64'b0100 : 64'b0011);
    endtask

    initial begin
        v[0] = '{"happy", 11, '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33,
                 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00},
                 8'h9A, 1'b1, 8'h06, 2, 32'h44332211, 32'h88776655};
        v[1] = '{"zero_len", 3, '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                 8'h00, 1'b1, 8'h06, 0, 32'h0, 32'h0};
        v[2] = '{"oversize", 3, '{8'hA5, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                 8'h00, 1'b0, 8'h15, 0, 32'h0, 32'h0};
        v[3] = '{"junk", 10, '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00,
                 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00},
                 8'hC7, 1'b1, 8'h06, 1, 32'hEFBEADDE, 32'h0};

        do_reset();
        rstB = 1'b0;
        #1 chk("reset_outs", outs(), 64'd2);
        do_reset();

        for (int k = 0; k < 4; k++) begin
            do_reset();
            send_vec(k);
            wait_tx({v[k].nm, "_tx"}, v[k].exp_tx, 0);
            chk_post({v[k].nm, "_post"}, v[k].exp_tx == 8'h06);
            chk({v[k].nm, "_we"}, 64'(we_cnt), 64'(v[k].exp_we));
            if (v[k].exp_we > 0) chk({v[k].nm, "_w0"}, 64'(mem[0]), 64'(v[k].w0));
            if (v[k].exp_we > 1) chk({v[k].nm, "_w1"}, 64'(mem[1]), 64'(v[k].w1));
        end

        // TX stall, then RUN must ignore further traffic
        do_reset();
        send_vec(0);
        wait_tx("stall_tx", 8'h06, 50);
        chk_post("stall_post", 1'b1);
        for (int i = 0; i < 7; i++) send_byte(v[0].b[i]);
        chk("run_no_we", 64'(we_cnt), 64'd2);
        chk_post("run_stays", 1'b1);

        // inter-byte timeout
        do_reset();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
        wait_tx("tmo_tx", 8'h15, 0);
        chk_post("tmo_post", 1'b0);
        chk("tmo_we", 64'(we_cnt), 64'd0);
        send_byte(8'hA5);
        chk("sync_clears_err", 64'(boot_err), 64'd0);
        send_byte(8'h00); send_byte(8'h00); send_ck(8'h00);
        wait_tx("tmo_retry_tx", 8'h06, 0);
        chk_post("tmo_retry_post", 1'b1);

        // framing error mid-data
        do_reset();
        for (int i = 0; i < 8; i++) send_byte(v[0].b[i]);
        rx_err = 1'b1;
        @(negedge clk);
        rx_err = 1'b0;
        wait_tx("rxerr_tx", 8'h15, 0);
        chk_post("rxerr_post", 1'b0);
        chk("rxerr_we", 64'(we_cnt), 64'd1);
        chk("rxerr_w0", 64'(mem[0]), 64'h44332211);

        // clkEn freeze mid-data, longer than the timeout
        do_reset();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        clkEn = 1'b0;
        send_byte(8'h99);
        rx_err = 1'b1;
        @(negedge clk);
        rx_err = 1'b0;
        repeat (400) @(negedge clk);
        chk("frz_outs", 64'({tx_valid, we_cnt[7:0]}), 64'd0);
        clkEn = 1'b1;
        send_byte(8'h33); send_byte(8'h44); send_ck(8'h55);
        wait_tx("frz_tx", 8'h06, 0);
        chk("frz_w0", 64'(mem[0]), 64'h44332211);

        // async reset mid-data
        do_reset();
        for (int i = 0; i < 8; i++) send_byte(v[0].b[i]);
        rstB = 1'b0;
        #1 chk("rst_mid_outs", outs(), 64'd2);
        @(negedge clk);
        rstB = 1'b1;

`ifdef BOOT_CHECKSUM_EN
        do_reset();
        for (int i = 0; i < 11; i++) send_byte(v[0].b[i]);
        send_byte(8'h9B);
        wait_tx("bad_ck_tx", 8'h15, 0);
        chk_post("bad_ck_post", 1'b0);
        send_vec(0);
        wait_tx("good_ck_tx", 8'h06, 0);
        chk_post("good_ck_post", 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
